// File: rtl/trade_uart_tx_if.sv
// ---------------------------------------------------------------------------
// trade_uart_tx_if
// Groups the trade capture inputs and the UART/status outputs of
// trade_uart_tx so that they travel as one bundle.
//   master : trade source / observer (drives trades and halt, reads status)
//   slave  : trade_uart_tx itself
// Signals:
//   trade_valid           one-cycle strobe, one trade per high cycle
//   trade_price/best_bid/best_ask  8-bit trade fields sampled with trade_valid
//   halt                  blocks the start of new frames
//   uart_tx               serial line, idles high
//   busy                  high from a frame's start bit through its last stop bit
//   fifo_full             FIFO holds FIFO_DEPTH entries
//   drop_count            trades lost to a full FIFO, saturating at 255
// ---------------------------------------------------------------------------
interface trade_uart_tx_if;
  logic       trade_valid;
  logic [7:0] trade_price;
  logic [7:0] best_bid;
  logic [7:0] best_ask;
  logic       halt;
  logic       uart_tx;
  logic       busy;
  logic       fifo_full;
  logic [7:0] drop_count;

  modport master (
    output trade_valid, trade_price, best_bid, best_ask, halt,
    input  uart_tx, busy, fifo_full, drop_count
  );

  modport slave (
    input  trade_valid, trade_price, best_bid, best_ask, halt,
    output uart_tx, busy, fifo_full, drop_count
  );
endinterface

// File: rtl/trade_uart_tx.sv
// ---------------------------------------------------------------------------
// trade_uart_tx
// Captures every reported trade into a small FIFO tagged with an 8-bit
// sequence number and serialises each entry as a 5-byte 8N1 frame
// (0xA5, seq, price, bid, ask), LSB first.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    trade_uart_tx_if.slave (trade inputs, halt, uart_tx, busy,
//          fifo_full, drop_count)
// ---------------------------------------------------------------------------
module trade_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  trade_uart_tx_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Byte idx of the frame: sync byte first, then seq, price, bid, ask.
  function automatic logic [7:0] frame_byte(input logic [31:0] frame, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hA5;
      3'd1:    b = frame[31:24];
      3'd2:    b = frame[23:16];
      3'd3:    b = frame[15:8];
      3'd4:    b = frame[7:0];
      default: b = 8'hA5;
    endcase
    return b;
  endfunction

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;
  logic [7:0]    seq_q, drop_q;
  logic          push_s, pop_s;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   frame_q, frame_d;
  logic          bit_done_s;
  logic [7:0]    cur_byte_s;
  logic          uart_tx_q, uart_tx_d;
  logic          busy_q, busy_d;

  // Fullness is the registered flag, so a pop in the same cycle cannot rescue a trade.
  assign push_s     = bus.trade_valid & ~full_q;
  assign bit_done_s = (timer_q == BIT_LAST);
  assign cur_byte_s = frame_byte(frame_q, byte_idx_q);

  // Occupancy update from push/pop; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy, sequence counter and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      seq_q    <= 8'd0;
      drop_q   <= 8'd0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      if (bus.trade_valid) seq_q <= seq_q + 8'd1;
      if (bus.trade_valid && full_q && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // FIFO storage: entry is {seq before increment, price, bid, ask}.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= {seq_q, bus.trade_price, bus.best_bid, bus.best_ask};
    end
  end

  // Frame FSM next-state; halt is only looked at while IDLE.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !bus.halt) begin
          pop_s      = 1'b1;
          frame_d    = mem_q[rd_ptr_q];
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          timer_d    = '0;
          state_d    = START;
        end else begin
          timer_d = '0;
        end
      end
      START: begin
        if (bit_done_s) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_done_s) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_done_s) begin
          timer_d = '0;
          if (byte_idx_q < 3'd4) begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy follow the current state, registered one cycle later.
  always_comb begin
    busy_d = (state_q != IDLE);
    case (state_q)
      IDLE:    uart_tx_d = 1'b1;
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = cur_byte_s[bit_idx_q];
      STOP:    uart_tx_d = 1'b1;
      default: uart_tx_d = 1'b1;
    endcase
  end

  // FSM state, timers, frame register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      frame_q    <= 32'd0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.uart_tx    = uart_tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = full_q;
  assign bus.drop_count = drop_q;

endmodule
